// File: rtl/reg_file_wb_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_wb_pkg
// Shared constants and types for the register file and its ALU neighbours.
//   WIDTH     : datapath width (matches ALU DATA1/DATA2/RESULT)
//   NREG      : number of architectural registers
//   ADDR_W    : register address width, log2(NREG)
//   stage_t   : one-entry write-back staging record (valid, addr, data, zero)
//   BYPASS_EN : 1 when read forwarding from the staging register is built in.
// Optional feature macro: REG_BYPASS_EN (define to enable read forwarding).
// -----------------------------------------------------------------------------
package reg_file_wb_pkg;

    localparam int WIDTH  = 8;
    localparam int NREG   = 8;
    localparam int ADDR_W = $clog2(NREG);

`ifdef REG_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        logic              zero;
    } stage_t;

    localparam stage_t STAGE_RESET = '{valid: 1'b0, addr: {ADDR_W{1'b0}},
                                       data: {WIDTH{1'b0}}, zero: 1'b0};

endpackage : reg_file_wb_pkg

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
// One combinational read port: array decode plus optional forwarding from
// the staging register.
// Ports:
//   regs_i  : current architectural register array contents
//   addr_i  : read address
//   stg_i   : staging record (uncommitted write)
//   data_o  : read data (array value, or staged data when forwarding applies)
//   match_o : addr_i hits a valid uncommitted write
// Behaviour depends on REG_BYPASS_EN through reg_file_wb_pkg::BYPASS_EN.
// -----------------------------------------------------------------------------
module reg_read_port
    import reg_file_wb_pkg::*;
(
    input  logic [WIDTH-1:0]  regs_i [NREG],
    input  logic [ADDR_W-1:0] addr_i,
    input  stage_t            stg_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              match_o
);

    logic fwd_s;

    // Address decode, hit detection against the pending write, and output mux.
    always_comb begin
        match_o = stg_i.valid & (addr_i == stg_i.addr);
        // In the non-forwarding build the select is constant 0 and the mux
        // collapses to a plain array read.
        fwd_s   = BYPASS_EN & match_o;
        if (fwd_s) begin
            data_o = stg_i.data;
        end else begin
            data_o = regs_i[addr_i];
        end
    end

endmodule : reg_read_port

// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
// Eight-entry, 8-bit register file with a one-entry write-back staging
// register between the ALU result and the array. A write sampled at edge N
// is held in the staging register and commits to the array at edge N+1.
// Ports:
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   IN, IN_ZERO           : ALU RESULT and ZERO flag to be written
//   INADDRESS, WRITE      : destination register and write request
//   OUT1ADDRESS/OUT1      : read port 1 (ALU DATA1)
//   OUT2ADDRESS/OUT2      : read port 2 (ALU DATA2)
//   ZERO_FLAG             : ZERO of the most recently committed write
//   HAZARD                : read hits an uncommitted write (non-forwarding build)
//   BUSY                  : staging register holds an uncommitted write
// Optional feature macro: REG_BYPASS_EN -- forward staged data to the read
// ports and tie HAZARD low.
// -----------------------------------------------------------------------------
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [WIDTH-1:0]  IN,
    input  logic              IN_ZERO,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              ZERO_FLAG,
    output logic              HAZARD,
    output logic              BUSY
);

    logic [WIDTH-1:0] regs_q [NREG];
    stage_t           stg_q;
    stage_t           stg_d;
    logic             zero_q;
    logic             match1_s;
    logic             match2_s;

    // Next staging record: capture a new write, otherwise just drop valid.
    always_comb begin
        stg_d = stg_q;
        if (WRITE) begin
            stg_d.valid = 1'b1;
            stg_d.addr  = INADDRESS;
            stg_d.data  = IN;
            stg_d.zero  = IN_ZERO;
        end else begin
            stg_d.valid = 1'b0;
        end
    end

    // Staging register and ZERO flag; the previous staged write commits on
    // the same edge that may load the next one.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stg_q  <= STAGE_RESET;
            zero_q <= 1'b0;
        end else begin
            stg_q <= stg_d;
            if (stg_q.valid) begin
                zero_q <= stg_q.zero;
            end else begin
                zero_q <= zero_q;
            end
        end
    end

    // Register array commit from the staging register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (stg_q.valid) begin
                regs_q[stg_q.addr] <= stg_q.data;
            end else begin
                regs_q[stg_q.addr] <= regs_q[stg_q.addr];
            end
        end
    end

    reg_read_port u_rd1 (
        .regs_i  (regs_q),
        .addr_i  (OUT1ADDRESS),
        .stg_i   (stg_q),
        .data_o  (OUT1),
        .match_o (match1_s)
    );

    reg_read_port u_rd2 (
        .regs_i  (regs_q),
        .addr_i  (OUT2ADDRESS),
        .stg_i   (stg_q),
        .data_o  (OUT2),
        .match_o (match2_s)
    );

    // Status outputs; HAZARD is forced low when forwarding resolves the hit.
    always_comb begin
        BUSY      = stg_q.valid;
        ZERO_FLAG = zero_q;
        HAZARD    = ~BYPASS_EN & (match1_s | match2_s);
    end

endmodule : reg_file_wb
